// File: rtl/sdc_drive_arbiter_if.sv
// Bus between the four drive requesters, the arbiter and the sd_rw sector engine.
// master = arbiter side, slave = requester / sd_rw side.
interface sdc_drive_arbiter_if #(
  parameter int NDRV = 4
);
  logic [NDRV-1:0]         req_rd;
  logic [NDRV-1:0]         req_wr;
  logic [24*NDRV-1:0]      req_lba;
  logic [32*NDRV-1:0]      drv_base;
  logic [NDRV-1:0]         img_mounted;
  logic [NDRV-1:0]         drv_busy;
  logic [NDRV-1:0]         drv_done;
  logic [NDRV-1:0]         drv_err;
  logic [NDRV-1:0]         drv_data_en;
  logic                    sd_rstart;
  logic                    sd_wstart;
  logic [31:0]             sd_sector;
  logic                    sd_rbusy;
  logic                    sd_rdone;
  logic                    sd_outen;
  logic [$clog2(NDRV)-1:0] grant;

  modport master (
    input  req_rd, req_wr, req_lba, drv_base, img_mounted,
    input  sd_rbusy, sd_rdone, sd_outen,
    output drv_busy, drv_done, drv_err, drv_data_en,
    output sd_rstart, sd_wstart, sd_sector, grant
  );

  modport slave (
    output req_rd, req_wr, req_lba, drv_base, img_mounted,
    output sd_rbusy, sd_rdone, sd_outen,
    input  drv_busy, drv_done, drv_err, drv_data_en,
    input  sd_rstart, sd_wstart, sd_sector, grant
  );
endinterface

// File: rtl/sdc_drive_arbiter.sv
// Shares one sd_rw sector engine between four drives, offsetting each drive's LBA
// by its partition base. Optional watchdog enabled by defining SDC_TIMEOUT_EN.
module sdc_drive_arbiter #(
  parameter int          NDRV    = 4,
  parameter logic [23:0] TIMEOUT = 24'd2000000
) (
  input  logic                clk,
  input  logic                rstn,
  sdc_drive_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    FINISH    = 3'd4,
    FAIL      = 3'd5,
    FAIL_END  = 3'd6
  } state_t;

  state_t          state_r;
  logic [1:0]      grant_r;
  logic            dir_wr_r;
  logic [31:0]     sector_r;
  logic [NDRV-1:0] busy_r;
  logic [NDRV-1:0] done_r;
  logic [NDRV-1:0] err_r;
  logic            rstart_r;
  logic            wstart_r;
  logic [NDRV-1:0] pend_s;
  logic            any_s;
  logic [1:0]      pick_s;
  logic [1:0]      cand_s;
  logic            tmo_hit_s;

  function automatic logic [3:0] onehot(input logic [1:0] g);
    onehot = 4'b0001 << g;
  endfunction

  assign pend_s = bus.req_rd | bus.req_wr;

  // Round-robin pick starting one past the last grant; the descending scan leaves the nearest hit.
  always_comb begin
    any_s  = 1'b0;
    pick_s = grant_r;
    cand_s = grant_r;
    for (int i = 4; i >= 1; i--) begin
      cand_s = grant_r + 2'(i);
      pick_s = pend_s[cand_s] ? cand_s : pick_s;
      any_s  = any_s | pend_s[cand_s];
    end
  end

`ifdef SDC_TIMEOUT_EN
  logic [23:0] tmo_cnt_r;

  assign tmo_hit_s = (tmo_cnt_r == (TIMEOUT - 24'd1));

  // Watchdog: cleared when the engine is started, counts while waiting on it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt_r <= 24'd0;
    end else if (state_r == ISSUE) begin
      tmo_cnt_r <= 24'd0;
    end else if ((state_r == WAIT_BUSY) || (state_r == WAIT_DONE)) begin
      tmo_cnt_r <= tmo_cnt_r + 24'd1;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end
`else
  logic unused_timeout;

  assign tmo_hit_s      = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Transfer sequencer with registered drive/engine outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r  <= IDLE;
      grant_r  <= 2'd0;
      dir_wr_r <= 1'b0;
      sector_r <= 32'd0;
      busy_r   <= 4'd0;
      done_r   <= 4'd0;
      err_r    <= 4'd0;
      rstart_r <= 1'b0;
      wstart_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          busy_r   <= 4'd0;
          done_r   <= 4'd0;
          err_r    <= 4'd0;
          rstart_r <= 1'b0;
          wstart_r <= 1'b0;
          if (any_s) begin
            grant_r  <= pick_s;
            dir_wr_r <= bus.req_wr[pick_s] & ~bus.req_rd[pick_s];
            sector_r <= bus.drv_base[32*pick_s +: 32] + {8'd0, bus.req_lba[24*pick_s +: 24]};
            state_r  <= bus.img_mounted[pick_s] ? ISSUE : FAIL;
          end else begin
            state_r  <= IDLE;
          end
        end
        ISSUE: begin
          busy_r   <= onehot(grant_r);
          rstart_r <= ~dir_wr_r;
          wstart_r <= dir_wr_r;
          state_r  <= WAIT_BUSY;
        end
        WAIT_BUSY, WAIT_DONE: begin
          rstart_r <= 1'b0;
          wstart_r <= 1'b0;
          // A done seen before busy still completes the transfer.
          if (bus.sd_rdone || tmo_hit_s) begin
            busy_r  <= 4'd0;
            done_r  <= onehot(grant_r);
            err_r   <= bus.sd_rdone ? 4'd0 : onehot(grant_r);
            state_r <= FINISH;
          end else if ((state_r == WAIT_BUSY) && bus.sd_rbusy) begin
            state_r <= WAIT_DONE;
          end else begin
            state_r <= state_r;
          end
        end
        FINISH: begin
          done_r  <= 4'd0;
          err_r   <= 4'd0;
          state_r <= IDLE;
        end
        FAIL: begin
          busy_r  <= onehot(grant_r);
          state_r <= FAIL_END;
        end
        FAIL_END: begin
          busy_r  <= 4'd0;
          done_r  <= onehot(grant_r);
          err_r   <= onehot(grant_r);
          state_r <= FINISH;
        end
        default: begin
          busy_r   <= 4'd0;
          done_r   <= 4'd0;
          err_r    <= 4'd0;
          rstart_r <= 1'b0;
          wstart_r <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign bus.drv_busy    = busy_r;
  assign bus.drv_done    = done_r;
  assign bus.drv_err     = err_r;
  assign bus.drv_data_en = ((state_r == WAIT_DONE) && bus.sd_outen) ? onehot(grant_r) : 4'd0;
  assign bus.sd_rstart   = rstart_r;
  assign bus.sd_wstart   = wstart_r;
  assign bus.sd_sector   = sector_r;
  assign bus.grant       = grant_r;

endmodule

// File: tb/tb_sdc_drive_arbiter.sv
// Scoreboard bench for sdc_drive_arbiter: the bench plays requesters and sd_rw.
module tb_sdc_drive_arbiter;

  typedef struct packed {
    logic [1:0]  drv;
    logic [31:0] sector;
    logic        wr;
    logic        err;
  } exp_t;

  logic clk;
  logic rstn;
  int   checks    = 0;
  int   failures  = 0;
  int   start_cnt = 0;
  int   den_cnt [4];
  exp_t sb_q [$];

  sdc_drive_arbiter_if #(.NDRV(4)) bus ();

  sdc_drive_arbiter #(.NDRV(4), .TIMEOUT(24'd100)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (bus.drv_data_en[i]) den_cnt[i] <= den_cnt[i] + 1;
    end
    if (bus.sd_rstart || bus.sd_wstart) start_cnt <= start_cnt + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
  endtask

  function automatic logic [51:0] outs();
    outs = {bus.drv_busy, bus.drv_done, bus.drv_err, bus.drv_data_en,
            bus.sd_rstart, bus.sd_wstart, bus.sd_sector, bus.grant};
  endfunction

  function automatic logic [47:0] exp_vec(input exp_t e, input int lat);
    logic [3:0] oh;
    oh = 4'b0001 << e.drv;
    exp_vec = {4'(lat), e.drv, e.sector, e.wr, 1'b0, oh, (e.err ? oh : 4'd0)};
  endfunction

  // Acts as sd_rw for one transfer: {latency, grant, sector, wr, start>1cyc, done, err}.
  task automatic serve(input int nbytes, output logic [47:0] obs);
    int         lat;
    logic [1:0] g;
    logic [31:0] sec;
    logic       wr;
    logic       lp;
    lat = 0;
    obs = 48'd0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bus.sd_rstart || bus.sd_wstart) begin
        lat = c;
        break;
      end
    end
    if (lat == 0) return;
    g   = bus.grant;
    sec = bus.sd_sector;
    wr  = bus.sd_wstart;
    bus.req_rd[g] = 1'b0;
    bus.req_wr[g] = 1'b0;
    tick();
    lp = bus.sd_rstart | bus.sd_wstart;
    bus.sd_rbusy = 1'b1;
    tick();
    for (int b = 0; b < nbytes; b++) begin
      bus.sd_outen = 1'b1;
      tick();
    end
    bus.sd_outen = 1'b0;
    bus.sd_rbusy = 1'b0;
    bus.sd_rdone = 1'b1;
    tick();
    obs = {4'(lat), g, sec, wr, lp, bus.drv_done, bus.drv_err};
    bus.sd_rdone = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (outs() !== 52'd0) begin
      failures++;
      $display("FAIL reset_asserted got=%h want=0", outs());
    end
    rstn = 1'b1;
    tick();
    tick();
    checks++;
    if (outs() !== 52'd0) begin
      failures++;
      $display("FAIL reset_idle got=%h want=0", outs());
    end
  endtask

  task automatic test_single_read();
    logic [47:0] obs;
    exp_t        e;
    bus.req_lba[48 +: 24]  = 24'h000010;
    bus.drv_base[64 +: 32] = 32'h00100000;
    sb_q.push_back('{drv: 2'd2, sector: 32'h00100010, wr: 1'b0, err: 1'b0});
    bus.req_rd[2] = 1'b1;
    serve(16, obs);
    e = sb_q.pop_front();
    checks++;
    if (obs !== exp_vec(e, 2)) begin
      failures++;
      $display("FAIL single_read got=%h want=%h", obs, exp_vec(e, 2));
    end
  endtask

  task automatic test_simultaneous();
    logic [47:0] obs;
    exp_t        e;
    do_reset();
    bus.drv_base[0 +: 32]  = 32'h00000100;
    bus.req_lba[0 +: 24]   = 24'h000001;
    bus.drv_base[32 +: 32] = 32'h00000200;
    bus.req_lba[24 +: 24]  = 24'h000002;
    bus.drv_base[96 +: 32] = 32'h00000400;
    bus.req_lba[72 +: 24]  = 24'h000004;
    sb_q.push_back('{drv: 2'd1, sector: 32'h00000202, wr: 1'b0, err: 1'b0});
    sb_q.push_back('{drv: 2'd3, sector: 32'h00000404, wr: 1'b0, err: 1'b0});
    sb_q.push_back('{drv: 2'd0, sector: 32'h00000101, wr: 1'b0, err: 1'b0});
    bus.req_rd = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      serve(2, obs);
      e = sb_q.pop_front();
      checks++;
      if (obs !== exp_vec(e, 2)) begin
        failures++;
        $display("FAIL simultaneous_%0d got=%h want=%h", k, obs, exp_vec(e, 2));
      end
    end
  endtask

  task automatic test_unmounted();
    logic [11:0] c1, c2, c3, c4;
    int          s0;
    bus.img_mounted = 4'b1110;
    s0 = start_cnt;
    bus.req_wr[0] = 1'b1;
    tick();
    c1 = {bus.drv_busy, bus.drv_done, bus.drv_err};
    tick();
    c2 = {bus.drv_busy, bus.drv_done, bus.drv_err};
    bus.req_wr[0] = 1'b0;
    tick();
    c3 = {bus.drv_busy, bus.drv_done, bus.drv_err};
    tick();
    c4 = {bus.drv_busy, bus.drv_done, bus.drv_err};
    bus.img_mounted = 4'b1111;
    checks++;
    if (c1 !== 12'h000) begin failures++; $display("FAIL unmounted_c1 got=%h want=000", c1); end
    checks++;
    if (c2 !== 12'h100) begin failures++; $display("FAIL unmounted_busy got=%h want=100", c2); end
    checks++;
    if (c3 !== 12'h011) begin failures++; $display("FAIL unmounted_done_err got=%h want=011", c3); end
    checks++;
    if (c4 !== 12'h000) begin failures++; $display("FAIL unmounted_clear got=%h want=000", c4); end
    checks++;
    if (start_cnt !== s0) begin
      failures++;
      $display("FAIL unmounted_no_start got=%0d want=%0d", start_cnt, s0);
    end
  endtask

  task automatic test_sector_wrap();
    logic [47:0] obs;
    exp_t        e;
    bus.drv_base[96 +: 32] = 32'hFFFFFFF0;
    bus.req_lba[72 +: 24]  = 24'h000020;
    sb_q.push_back('{drv: 2'd3, sector: 32'h00000010, wr: 1'b1, err: 1'b0});
    bus.req_wr[3] = 1'b1;
    serve(4, obs);
    e = sb_q.pop_front();
    checks++;
    if (obs !== exp_vec(e, 2)) begin
      failures++;
      $display("FAIL sector_wrap got=%h want=%h", obs, exp_vec(e, 2));
    end
  endtask

  task automatic test_data_routing();
    logic [47:0] obs;
    exp_t        e;
    int          b0, b1, b2, b3;
    b0 = den_cnt[0]; b1 = den_cnt[1]; b2 = den_cnt[2]; b3 = den_cnt[3];
    bus.sd_outen = 1'b1;
    tick();
    bus.sd_outen = 1'b0;
    bus.sd_rdone = 1'b1;
    tick();
    bus.sd_rdone = 1'b0;
    checks++;
    if ((den_cnt[0] + den_cnt[1] + den_cnt[2] + den_cnt[3]) !== (b0 + b1 + b2 + b3)) begin
      failures++;
      $display("FAIL stray_outen got=%0d want=%0d", den_cnt[0] + den_cnt[1] + den_cnt[2] + den_cnt[3], b0 + b1 + b2 + b3);
    end
    checks++;
    if (bus.drv_done !== 4'd0) begin
      failures++;
      $display("FAIL stray_rdone got=%b want=0000", bus.drv_done);
    end
    bus.drv_base[32 +: 32] = 32'h00ABC000;
    bus.req_lba[24 +: 24]  = 24'h000123;
    sb_q.push_back('{drv: 2'd1, sector: 32'h00ABC123, wr: 1'b0, err: 1'b0});
    bus.req_rd[1] = 1'b1;
    bus.req_wr[1] = 1'b1;
    serve(512, obs);
    e = sb_q.pop_front();
    checks++;
    if (obs !== exp_vec(e, 2)) begin
      failures++;
      $display("FAIL routing_xfer got=%h want=%h", obs, exp_vec(e, 2));
    end
    checks++;
    if ((den_cnt[1] - b1) != 512 || den_cnt[0] != b0 || den_cnt[2] != b2 || den_cnt[3] != b3) begin
      failures++;
      $display("FAIL routing_count got=%0d/%0d/%0d/%0d want=0/512/0/0",
               den_cnt[0] - b0, den_cnt[1] - b1, den_cnt[2] - b2, den_cnt[3] - b3);
    end
  endtask

  task automatic test_drop_after_grant();
    logic [47:0] obs;
    exp_t        e;
    sb_q.push_back('{drv: 2'd1, sector: 32'h00ABC123, wr: 1'b0, err: 1'b0});
    bus.req_rd[1] = 1'b1;
    tick();
    bus.req_rd[1] = 1'b0;
    serve(3, obs);
    e = sb_q.pop_front();
    checks++;
    if (obs !== exp_vec(e, 1)) begin
      failures++;
      $display("FAIL drop_after_grant got=%h want=%h", obs, exp_vec(e, 1));
    end
  endtask

`ifdef SDC_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    logic [7:0] de;
    bus.req_rd[2] = 1'b1;
    tick();
    tick();
    bus.req_rd[2] = 1'b0;
    bus.sd_rbusy = 1'b1;
    for (n = 1; n <= 200; n++) begin
      tick();
      if (bus.drv_done !== 4'd0) break;
    end
    de = {bus.drv_done, bus.drv_err};
    checks++;
    if (n != 100 || de !== 8'h44) begin
      failures++;
      $display("FAIL timeout got=cycle %0d done_err %h want=cycle 100 done_err 44", n, de);
    end
    bus.sd_rbusy = 1'b0;
    tick();
    bus.sd_rdone = 1'b1;
    tick();
    bus.sd_rdone = 1'b0;
    checks++;
    if (bus.drv_done !== 4'd0) begin
      failures++;
      $display("FAIL late_rdone got=%b want=0000", bus.drv_done);
    end
  endtask
`endif

  task automatic test_reset_mid_transfer();
    bus.req_rd[0] = 1'b1;
    tick();
    tick();
    bus.req_rd[0] = 1'b0;
    tick();
    bus.sd_rbusy = 1'b1;
    tick();
    bus.sd_outen = 1'b1;
    #1;
    checks++;
    if (bus.drv_data_en !== 4'b0001) begin
      failures++;
      $display("FAIL data_en_comb got=%b want=0001", bus.drv_data_en);
    end
    #1;
    rstn = 1'b0;
    #1;
    checks++;
    if (outs() !== 52'd0) begin
      failures++;
      $display("FAIL reset_mid_transfer got=%h want=0", outs());
    end
    bus.sd_outen = 1'b0;
    bus.sd_rbusy = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    rstn            = 1'b0;
    bus.req_rd      = 4'd0;
    bus.req_wr      = 4'd0;
    bus.req_lba     = 96'd0;
    bus.drv_base    = 128'd0;
    bus.img_mounted = 4'b1111;
    bus.sd_rbusy    = 1'b0;
    bus.sd_rdone    = 1'b0;
    bus.sd_outen    = 1'b0;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_unmounted();
    test_sector_wrap();
    test_data_routing();
    test_drop_after_grant();
`ifdef SDC_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_transfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdc_drive_arbiter.md
Name: sdc_drive_arbiter

Overview:
- Shares the single sd_rw sector engine between four drive requesters: floppy 0, floppy 1, SCSI 0 and SCSI 1.
- Each requester has its own 24-bit image-relative LBA. The block adds that LBA to the drive's 32-bit partition base on the SD card, so every drive image occupies its own region of the card.
- Sits between the macplus sdc_* interface and sd_rw. It sequences one transfer at a time and routes the byte stream and completion back to the granted drive.

Parameters:
- NDRV, 4, number of requesters; the design is fixed to 4, the parameter exists for port-width derivation only.
- TIMEOUT, 24'd2000000, watchdog limit in clk cycles; only used when SDC_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- req_rd  in  4  per-drive read request, level
- req_wr  in  4  per-drive write request, level
- req_lba  in  96  per-drive LBA; drive n uses bits [24n+23:24n]
- drv_base  in  128  per-drive SD base sector; drive n uses bits [32n+31:32n]
- img_mounted  in  4  per-drive image-present flag
- drv_busy  out  4  one-hot: granted drive is being serviced
- drv_done  out  4  one-hot, 1-cycle completion pulse
- drv_err  out  4  one-hot, 1-cycle error pulse (coincident with drv_done)
- drv_data_en  out  4  one-hot copy of sd_outen for the granted drive
- sd_rstart  out  1  read start to sd_rw
- sd_wstart  out  1  write start to sd_rw
- sd_sector  out  32  absolute sector to sd_rw
- sd_rbusy  in  1  sd_rw busy
- sd_rdone  in  1  sd_rw done pulse
- sd_outen  in  1  sd_rw byte strobe
- grant  out  2  index of the current or last granted drive

Behaviour:
- Reset (rstn low, async): state=IDLE; all outputs 0; grant=0; round-robin pointer=0.
- Requests: a drive is pending when req_rd[n] or req_wr[n] is high. If both are high, read wins. The requester holds its request until it sees drv_busy[n], then drops it.
- Arbitration: round-robin starting at pointer+1 (mod 4). After a grant, pointer=grant.
- State IDLE: if any request is pending, choose drive g and register:
  - grant=g
  - dir = write if req_wr[g] and not req_rd[g], else read
  - sd_sector = drv_base[g] + zero-extended req_lba[g], 32-bit modulo (wrap-around, no saturation)
  - next state: ISSUE if img_mounted[g], else FAIL.
- State ISSUE: drv_busy[g]=1; sd_rstart or sd_wstart high for exactly 1 cycle; next state WAIT_BUSY.
- State WAIT_BUSY: drv_busy held; wait for sd_rbusy=1, then go to WAIT_DONE. If sd_rdone arrives in the same cycle, or before busy was seen, go directly to FINISH.
- State WAIT_DONE: drv_busy held; drv_data_en[g]=sd_outen, combinational with zero latency. On sd_rdone go to FINISH.
- State FINISH: drv_done[g]=1 for 1 cycle; drv_busy cleared in the same cycle; next state IDLE.
- State FAIL: drv_busy[g]=1 for 1 cycle; then drv_done[g]=1 and drv_err[g]=1 for 1 cycle; the SD engine is not started; next state IDLE.
- Timing:
  - Minimum 1 idle cycle between transfers; no back-to-back grant in the FINISH cycle.
  - Request-to-start latency: 2 cycles (IDLE register, then ISSUE).
- Boundary rules:
  - sd_sector stays stable from ISSUE until the next grant.
  - drv_data_en is 0 outside WAIT_DONE.
  - sd_outen or sd_rdone arriving in IDLE is ignored.
  - A request dropped after grant has no effect; the transfer completes.
  - Two requests arriving in the same cycle are resolved by round-robin order.
  - Reset in mid-transfer: all outputs return to 0 immediately; sd_rw is reset from the same rstn.

Optional Feature:
- Macro: SDC_TIMEOUT_EN.
- Defined: a 24-bit counter clears on ISSUE and counts every cycle in WAIT_BUSY and WAIT_DONE. When it reaches TIMEOUT-1 without sd_rdone, the block goes to FINISH with drv_err[g]=1 alongside drv_done[g]. A late sd_rdone that then arrives in IDLE is ignored.
- Not defined: no counter; the block waits for sd_rdone indefinitely; drv_err is only produced by FAIL.

Test Plan:
- Single read: drive 2, req_lba=0x000010, drv_base[2]=0x00100000 -> sd_sector=0x00100010; sd_rstart pulses 1 cycle, 2 cycles after request; drv_done[2] pulses 1 cycle after sd_rdone.
- Simultaneous requests: req_rd=4'b1011 after reset (pointer 0) -> grant order 1, 3, 0; each drv_done is one-hot; no overlapping sd_rstart pulses.
- Unmounted drive: req_wr[0], img_mounted=4'b1110 -> sd_wstart never asserted; drv_done[0]=drv_err[0]=1 exactly 3 cycles after request.
- Sector wrap: drv_base=0xFFFFFFF0, lba=0x20 -> sd_sector=0x00000010; no error.
- Data routing: 512 sd_outen strobes during drive 1 read -> exactly 512 drv_data_en[1] pulses; drv_data_en of other drives stays 0; a stray sd_outen in IDLE produces none.
- Timeout (SDC_TIMEOUT_EN, TIMEOUT=100): sd_rbusy held high, no sd_rdone -> drv_done=drv_err=1 at cycle 100 after ISSUE; rstn pulse mid-WAIT_DONE -> all outputs 0 immediately.
